// File: rtl/multi_pkg.sv
// Shared types and default sizing for the start/done initiator.
package multi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_e;

    localparam int WIDTH_DEF   = 32;
    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/multi_init_timer.sv
// WAIT-state watchdog: counts stalled cycles and flags the last allowed one.
module multi_init_timer
    import multi_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the TIMEOUT-th WAIT cycle (count starts at 0).
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multi_initiator.sv
// Sequences one request at a time into a start/done multi-cycle unit.
// Define MULTI_INIT_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
module multi_initiator
    import multi_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             dut_start,
    output logic [WIDTH-1:0] dut_inp,
    input  logic             dut_done,
    input  logic [WIDTH-1:0] dut_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               dut_start_q, dut_start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   txn_q, txn_d;
    logic               expired;

`ifdef MULTI_INIT_TIMEOUT_EN
    multi_init_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == START),
        .enable  ((state_q == WAIT) && !dut_done),
        .expired (expired)
    );
`else
    // TIMEOUT < 2 is illegal, so this is constant 0: WAIT is unbounded.
    assign expired = (TIMEOUT < 2);
`endif

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        txn_d      = txn_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    opnd_d  = req_data;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (dut_done) begin
                    rsp_data_d = dut_out;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (expired) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    txn_d   = txn_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        dut_start_d = (state_d == START);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            opnd_q      <= '0;
            dut_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            txn_q       <= '0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            dut_start_q <= dut_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            txn_q       <= txn_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign dut_start = dut_start_q;
    assign dut_inp   = opnd_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_multi_initiator.sv
// Directed + randomized bench for multi_initiator with a transaction-level model.
module tb_multi_initiator;

    localparam int TO = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_data;
    logic          dut_start;
    logic [31:0]   dut_inp;
    logic          dut_done;
    logic [31:0]   dut_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [CW-1:0] txn_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    int starts = 0;

    multi_initiator #(
        .WIDTH   (32),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .dut_start (dut_start),
        .dut_inp   (dut_inp),
        .dut_done  (dut_done),
        .dut_out   (dut_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (dut_start === 1'b1) starts++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: done arriving on WAIT cycle k is honoured unless the watchdog
    // already fired (k > TO with the feature enabled).
    function automatic bit times_out(input int k);
`ifdef MULTI_INIT_TIMEOUT_EN
        return k > TO;
`else
        return (k < 0);
`endif
    endfunction

    task automatic txn(input logic [31:0] d, input logic [31:0] r,
                       input int k, input int hold, input bit spur);
        logic [31:0] er;
        bit          ee;
        int          n;
        ee = times_out(k);
        er = ee ? 32'h0 : r;
        n  = ee ? TO : k;
        chk("idle_ready", 32'(req_ready), 1);
        chk("idle_start", 32'(dut_start), 0);
        req_valid = 1'b1;
        req_data  = d;
        @(negedge clock);
        req_valid = 1'b0;
        req_data  = $urandom;
        chk("start_pulse", 32'(dut_start), 1);
        chk("start_ready", 32'(req_ready), 0);
        chk("start_inp", dut_inp, d);
        if (spur) begin
            dut_done = 1'b1;
            dut_out  = 32'hDEAD;
        end
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            dut_done = 1'b0;
            chk("wait_start", 32'(dut_start), 0);
            chk("wait_inp", dut_inp, d);
            chk("wait_valid", 32'(rsp_valid), 0);
            if (i == k) begin
                dut_done = 1'b1;
                dut_out  = r;
            end
        end
        @(negedge clock);
        dut_done = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_data", rsp_data, er);
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        chk("rsp_ready_lo", 32'(req_ready), 0);
        for (int i = 0; i < hold; i++) begin
            if (spur) begin
                dut_done = 1'b1;
                dut_out  = 32'hDEAD;
            end
            @(negedge clock);
            dut_done = 1'b0;
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", rsp_data, er);
            chk("hold_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        chk("post_valid", 32'(rsp_valid), 0);
        chk("post_ready", 32'(req_ready), 1);
        chk("post_busy", 32'(busy), 0);
        chk("post_count", 32'(txn_count), 32'(exp_cnt));
    endtask

    initial begin
        int s0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        dut_done  = 1'b0;
        dut_out   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_start", 32'(dut_start), 0);
        chk("rst_inp", dut_inp, 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(txn_count), 0);
        reset = 1'b0;

        txn(32'h0000_00A5, 32'h0000_014A, 3, 0, 1'b0);
        txn(32'h0000_1234, 32'h0000_BEEF, 2, 5, 1'b1);

        // Back-to-back with req_valid held high.
        s0 = starts;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_data = 32'(i + 1);
            chk("b2b_ready", 32'(req_ready), 1);
            @(negedge clock);
            req_data = 32'hFFFF_FFFF;
            chk("b2b_inp_s", dut_inp, 32'(i + 1));
            @(negedge clock);
            chk("b2b_inp_w", dut_inp, 32'(i + 1));
            dut_done = 1'b1;
            dut_out  = 32'((i + 1) * 7);
            @(negedge clock);
            dut_done = 1'b0;
            chk("b2b_valid", 32'(rsp_valid), 1);
            chk("b2b_data", rsp_data, 32'((i + 1) * 7));
            @(negedge clock);
            exp_cnt = (exp_cnt + 1) % (1 << CW);
            if (i == 2) req_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        @(negedge clock);
        chk("b2b_starts", 32'(starts - s0), 3);
        chk("b2b_count", 32'(txn_count), 32'(exp_cnt));
        chk("b2b_idle", 32'(busy), 0);

        // Reset while waiting for done; the late done must be ignored.
        req_valid = 1'b1;
        req_data  = 32'h55;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        dut_done = 1'b1;
        dut_out  = 32'h77;
        @(negedge clock);
        dut_done = 1'b0;
        exp_cnt  = 0;
        chk("mrst_ready", 32'(req_ready), 1);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_valid", 32'(rsp_valid), 0);
        chk("mrst_count", 32'(txn_count), 0);
        @(negedge clock);
        chk("mrst_valid2", 32'(rsp_valid), 0);
        chk("mrst_data", rsp_data, 0);

        // Seventeen transactions wrap a 4-bit counter back to 1.
        for (int i = 0; i < 17; i++) begin
            txn($urandom, $urandom, int'($urandom_range(1, 6)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        chk("wrap_count", 32'(txn_count), 1);

`ifdef MULTI_INIT_TIMEOUT_EN
        txn(32'h0000_0009, 32'h0000_0099, TO + 4, 3, 1'b1);
        txn(32'h0000_000A, 32'h0000_00AA, TO, 0, 1'b0);
        txn(32'h0000_000B, 32'h0000_00BB, TO + 1, 0, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            txn($urandom, $urandom, int'($urandom_range(1, 12)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_initiator.md
Name: multi_initiator

Overview:
Initiator side of the start/done multi-cycle handshake.
- Accepts a request on a valid/ready stream.
- Drives start and inp to a multi-cycle unit such as multi0 or multi2multi.
- Waits for done, captures out, and returns it on a valid/ready response stream.
- Used as the bus-facing front end that sequences one transaction at a time into a multi-cycle datapath.

Parameters:
- WIDTH, 32, data width of request, unit input/output and response.
- TIMEOUT, 64, WAIT-state cycle limit before abort (used only with MULTI_INIT_TIMEOUT_EN); must be >= 2.
- CNT_W, 16, width of completed-transaction counter.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  initiator can accept a request.
- req_data  in  WIDTH  request operand.
- dut_start  out  1  one-cycle start pulse to the unit.
- dut_inp  out  WIDTH  operand to the unit.
- dut_done  in  1  unit result valid, one-cycle pulse.
- dut_out  in  WIDTH  unit result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured result.
- rsp_err  out  1  response is a timeout abort.
- busy  out  1  state != IDLE.
- txn_count  out  CNT_W  completed-response counter.

Behaviour:
- Reset: state=IDLE; req_ready=1 (combinational from IDLE); dut_start=0; dut_inp=0; rsp_valid=0; rsp_data=0; rsp_err=0; busy=0; txn_count=0. Reset mid-transaction abandons it; any later dut_done is ignored.
- States: IDLE, START, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch req_data into the operand register and go to START. Without req_valid, stay.
- START: dut_start=1 for exactly this one cycle; go to WAIT unconditionally. dut_done during START is ignored, because the unit's done cannot coincide with its start.
- WAIT: dut_start=0.
  - On dut_done: register dut_out into rsp_data, clear rsp_err, go to RESP.
- dut_inp: equals the operand register and is held stable from START through the end of WAIT. It keeps its value in RESP/IDLE until the next accept.
- RESP: rsp_valid=1, rsp_data/rsp_err stable. On rsp_ready: increment txn_count (wraps modulo 2^CNT_W) and go to IDLE. rsp_valid falls the next cycle.
- req_ready=0 in START/WAIT/RESP. Only one transaction is in flight; no request buffering.
- dut_done outside WAIT (IDLE, START, RESP) is ignored and never changes rsp_data.
- Latency:
  - Accept at cycle T → dut_start at T+1.
  - Done at cycle D → rsp_valid at D+1.
  - Response accepted at R → req_ready at R+1.
  - Minimum request-to-request spacing is 4 cycles plus the unit latency.

Optional Feature:
- MULTI_INIT_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without dut_done.
  - If TIMEOUT WAIT cycles elapse without done, go to RESP with rsp_err=1 and rsp_data=0.
  - dut_done in the same cycle the limit is reached wins: normal response, rsp_err=0.
  - A late done after abort is ignored.
  - Aborted responses also increment txn_count on handshake.
- Not defined: no counter logic, rsp_err tied 0, WAIT waits indefinitely.

Decomposition:
- Package multi_pkg: state enum (IDLE, START, WAIT, RESP) and default WIDTH/TIMEOUT/CNT_W localparams.
- Sub-module multi_init_timer, the timeout counter with clear/enable/expired. Instantiated only under MULTI_INIT_TIMEOUT_EN.

Test Plan:
- Single transaction:
  - Stimulus: req_data=0x0000_00A5 accepted at cycle 2; unit done 3 cycles after start with dut_out=0x0000_014A.
  - Response: dut_start high only at cycle 3; rsp_valid at cycle 7 with rsp_data=0x14A, rsp_err=0; txn_count=1 after handshake.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - Response: rsp_data stable, req_ready=0 throughout; a spurious dut_done with dut_out=0xDEAD during RESP leaves rsp_data unchanged.
- Back-to-back:
  - Stimulus: req_valid held high with data 1, 2, 3 and rsp_ready=1.
  - Response: exactly three dut_start pulses, responses in order, txn_count=3, dut_inp stable while busy.
- Reset mid-WAIT:
  - Stimulus: reset asserted one cycle in WAIT, then dut_done pulses.
  - Response: state IDLE, rsp_valid=0, txn_count=0; no response produced.
- Timeout (macro on, TIMEOUT=8):
  - Stimulus: no dut_done.
  - Response: rsp_valid 9 cycles after start with rsp_err=1, rsp_data=0; a later done is ignored. Done on the 8th WAIT cycle gives a normal response.
- Wrap (CNT_W=4):
  - Stimulus: 17 transactions.
  - Response: txn_count=1.
